// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizes and state type for the round-robin mux arbiter.
package mux_arb_pkg;
    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search for the first set req bit at or after start.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;
    always_comb begin
        rot = N_REQ'({req, req} >> start);
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) if (rot[i]) off = SEL_W'(i);
        idx = start + off;
        found = |req;
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin grant sequencer driving a shared 8:1 select with registered data.
// Define ARB_GRANT_COUNT_EN to add the saturating grant_count output.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data,
    output logic [N_REQ-1:0]        gnt,
    output logic [SEL_W-1:0]        sel,
    output logic                    busy,
    output logic [DATA_W-1:0]       y,
    output logic                    y_valid
`ifdef ARB_GRANT_COUNT_EN
    ,
    output logic [7:0]              grant_count
`endif
);
    state_t state, state_n;
    logic [SEL_W-1:0] ptr, start, idx;
    logic [CNT_W-1:0] cnt;
    logic found, release_now, grant_start;
    logic [DATA_W-1:0] y_sel;

    rr_pick u_pick (.req(req), .start(start), .idx(idx), .found(found));

    // on release the search starts just past the current owner, so it is considered last
    always_comb begin
        release_now = state == BUSY && (!req[sel] || cnt == CNT_W'(MAX_BURST));
        start = release_now ? sel + SEL_W'(1) : ptr;
        grant_start = found && (state == IDLE || release_now);
        state_n = (state == BUSY && !release_now) || grant_start ? BUSY : IDLE;
        y_sel = data[sel*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            sel     <= '0;
            busy    <= 1'b0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            state   <= state_n;
            busy    <= state_n == BUSY;
            y_valid <= state == BUSY;
            if (state == BUSY) y <= y_sel;
            if (release_now) ptr <= sel + SEL_W'(1);
            if (grant_start) begin
                sel <= idx;
                gnt <= N_REQ'(1) << idx;
                cnt <= CNT_W'(1);
            end else if (release_now) gnt <= '0;
            else if (state == BUSY) cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef ARB_GRANT_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) grant_count <= '0;
        else if (grant_start && grant_count != 8'hFF) grant_count <= grant_count + 8'd1;
    end
`endif
endmodule
